// File: rtl/iir_biquad_seq_pkg.sv
// Shared constants and types for the time-multiplexed biquad cascade engine.
package iir_biquad_seq_pkg;

  localparam int unsigned N_SEC  = 5;           // biquad sections
  localparam int unsigned DW     = 16;          // sample width, Q1.15
  localparam int unsigned CW     = 16;          // coefficient width, Q2.14
  localparam int unsigned AW     = 40;          // accumulator width
  localparam int unsigned FRAC   = 14;          // product shift
  localparam int unsigned N_ADDR = 5 * N_SEC;   // coefficient ROM depth
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned SEC_W  = 3;
  localparam int unsigned SLOT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // MAC slot within a section, equal to coefficient address mod 5
  localparam logic [SLOT_W-1:0] SLOT_B0 = 3'd0;
  localparam logic [SLOT_W-1:0] SLOT_B1 = 3'd1;
  localparam logic [SLOT_W-1:0] SLOT_B2 = 3'd2;
  localparam logic [SLOT_W-1:0] SLOT_A1 = 3'd3;
  localparam logic [SLOT_W-1:0] SLOT_A2 = 3'd4;

endpackage

// File: rtl/iir_biquad_seq_mac_round.sv
// Combinational MAC step: signed multiply, add/sub into the accumulator,
// round half up, arithmetic shift, then saturate (IIR_SAT_EN) or wrap.
module iir_mac_round
  import iir_biquad_seq_pkg::*;
(
  input  logic signed [AW-1:0] acc_i,
  input  logic signed [DW-1:0] data_i,
  input  logic signed [CW-1:0] coeff_i,
  input  logic                 sub_i,
  output logic signed [AW-1:0] acc_o,
  output logic        [DW-1:0] y_o
`ifdef IIR_SAT_EN
  ,
  output logic                 clamp_o
`endif
);

  localparam logic signed [AW-1:0] RND = AW'(1 << (FRAC - 1));

  logic signed [DW+CW-1:0] prod;
  logic signed [AW-1:0]    prod_ext;
  logic signed [AW-1:0]    rnd;

  // Multiply, accumulate and add the rounding constant
  always_comb begin
    prod     = data_i * coeff_i;
    prod_ext = {{(AW-DW-CW){prod[DW+CW-1]}}, prod};
    acc_o    = sub_i ? (acc_i - prod_ext) : (acc_i + prod_ext);
    rnd      = acc_o + RND;
  end

`ifdef IIR_SAT_EN
  logic signed [AW-1:0] shifted;
  logic        [AW-DW:0] hi;

  // Clamp to the Q1.15 range when the bits above the sign are not a pure extension
  always_comb begin
    shifted = rnd >>> FRAC;
    hi      = shifted[AW-1:DW-1];
    clamp_o = (hi != '0) && (hi != '1);
    y_o     = clamp_o ? {shifted[AW-1], {(DW-1){~shifted[AW-1]}}} : shifted[DW-1:0];
  end
`else
  // Two's-complement wrap: keep the low DW bits of the shifted result
  always_comb begin
    y_o = DW'(rnd >>> FRAC);
  end
`endif

endmodule

// File: rtl/iir_biquad_seq.sv
// 5-section Direct-Form-I biquad cascade, one MAC per cycle against an
// external combinational coefficient ROM. Optional macro IIR_SAT_EN selects
// saturating section outputs and adds the sticky ovf port.
module iir_biquad_seq
  import iir_biquad_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  output logic [ADDR_W-1:0] coeff_addr,
  input  logic [CW-1:0]     coeff,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
`ifdef IIR_SAT_EN
  output logic              ovf,
`endif
  output logic              busy
);

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [SLOT_W-1:0]       slot_q, slot_d;
  logic [SEC_W-1:0]        sec_q, sec_d;
  logic signed [AW-1:0]    acc_q, acc_d, acc_next;
  logic signed [DW-1:0]    s_q, s_d;
  logic signed [DW-1:0]    x1_q [N_SEC];
  logic signed [DW-1:0]    x1_d [N_SEC];
  logic signed [DW-1:0]    x2_q [N_SEC];
  logic signed [DW-1:0]    x2_d [N_SEC];
  logic signed [DW-1:0]    y1_q [N_SEC];
  logic signed [DW-1:0]    y1_d [N_SEC];
  logic signed [DW-1:0]    y2_q [N_SEC];
  logic signed [DW-1:0]    y2_d [N_SEC];
  logic [DW-1:0]           out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    in_ready_q, in_ready_d;
  logic                    busy_q, busy_d;
  logic signed [DW-1:0]    operand;
  logic                    sub_op;
  logic [DW-1:0]           y;
`ifdef IIR_SAT_EN
  logic                    ovf_q, ovf_d;
  logic                    clamp;
`endif

  // Select the MAC operand for the current slot of the current section
  always_comb begin
    operand = s_q;
    sub_op  = 1'b0;
    case (slot_q)
      SLOT_B1: operand = x1_q[sec_q];
      SLOT_B2: operand = x2_q[sec_q];
      SLOT_A1: begin operand = y1_q[sec_q]; sub_op = 1'b1; end
      SLOT_A2: begin operand = y2_q[sec_q]; sub_op = 1'b1; end
      default: operand = s_q;
    endcase
  end

  iir_mac_round u_mac (
    .acc_i   (acc_q),
    .data_i  (operand),
    .coeff_i (coeff),
    .sub_i   (sub_op),
    .acc_o   (acc_next),
    .y_o     (y)
`ifdef IIR_SAT_EN
    ,
    .clamp_o (clamp)
`endif
  );

  // FSM next state, counters, history updates and registered outputs
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    slot_d     = slot_q;
    sec_d      = sec_q;
    acc_d      = acc_q;
    s_d        = s_q;
    x1_d       = x1_q;
    x2_d       = x2_q;
    y1_d       = y1_q;
    y2_d       = y2_q;
    out_data_d = out_data_q;
`ifdef IIR_SAT_EN
    ovf_d      = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d = RUN;
          s_d     = in_data;
          addr_d  = '0;
          slot_d  = SLOT_B0;
          sec_d   = '0;
          acc_d   = '0;
`ifdef IIR_SAT_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      RUN: begin
        addr_d = addr_q + ADDR_W'(1);
        if (slot_q == SLOT_A2) begin
          // Section finished: shift its history and feed y to the next section
          x2_d[sec_q] = x1_q[sec_q];
          x1_d[sec_q] = s_q;
          y2_d[sec_q] = y1_q[sec_q];
          y1_d[sec_q] = y;
          s_d         = y;
          acc_d       = '0;
          slot_d      = SLOT_B0;
          sec_d       = sec_q + SEC_W'(1);
`ifdef IIR_SAT_EN
          if (clamp) ovf_d = 1'b1;
`endif
          if (sec_q == SEC_W'(N_SEC - 1)) begin
            state_d    = DONE;
            out_data_d = y;
            addr_d     = '0;
            sec_d      = '0;
          end
        end else begin
          acc_d  = acc_next;
          slot_d = slot_q + SLOT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // State and history registers; reset aborts any sample in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      slot_q      <= '0;
      sec_q       <= '0;
      acc_q       <= '0;
      s_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
`ifdef IIR_SAT_EN
      ovf_q       <= 1'b0;
`endif
      for (int unsigned i = 0; i < N_SEC; i++) begin
        x1_q[i] <= '0;
        x2_q[i] <= '0;
        y1_q[i] <= '0;
        y2_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      slot_q      <= slot_d;
      sec_q       <= sec_d;
      acc_q       <= acc_d;
      s_q         <= s_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
`ifdef IIR_SAT_EN
      ovf_q       <= ovf_d;
`endif
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      y1_q        <= y1_d;
      y2_q        <= y2_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign coeff_addr = addr_q;
  assign busy       = busy_q;
`ifdef IIR_SAT_EN
  assign ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_iir_biquad_seq.sv
// Directed bench for iir_biquad_seq with a local coefficient ROM and a
// floating-free integer reference filter for long response sequences.
module tb_iir_biquad_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [4:0]  coeff_addr;
  logic [15:0] coeff;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;
`ifdef IIR_SAT_EN
  logic        ovf;
  bit          m_ovf;
`endif

  int errors = 0;
  int checks = 0;

  int m_x1 [5];
  int m_x2 [5];
  int m_y1 [5];
  int m_y2 [5];

  iir_biquad_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .coeff_addr (coeff_addr),
    .coeff      (coeff),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
`ifdef IIR_SAT_EN
    .ovf        (ovf),
`endif
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Coefficient ROM: b0 = 0x0E29 in every section, a2 differs per section
  function automatic int coef(input int a);
    int sec;
    int sl;
    if (a >= 25) return 0;
    sec = a / 5;
    sl  = a % 5;
    case (sl)
      0:       return 3625;
      1:       return 7250;
      2:       return 3625;
      3:       return -19661;
      default: return 8192 - 1024 * sec;
    endcase
  endfunction

  assign coeff = 16'(coef(int'(coeff_addr)));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mdl_reset();
    for (int k = 0; k < 5; k++) begin
      m_x1[k] = 0; m_x2[k] = 0; m_y1[k] = 0; m_y2[k] = 0;
    end
`ifdef IIR_SAT_EN
    m_ovf = 1'b0;
`endif
  endtask

  // Bit-true DF-I cascade reference
  task automatic mdl_step(input logic [15:0] d, output logic [15:0] y);
    longint acc;
    longint sh;
    int     s;
    int     so;
`ifndef IIR_SAT_EN
    logic [15:0] t;
`endif
    s = int'($signed(d));
`ifdef IIR_SAT_EN
    m_ovf = 1'b0;
`endif
    for (int k = 0; k < 5; k++) begin
      acc = longint'(s) * coef(5*k) + longint'(m_x1[k]) * coef(5*k+1)
          + longint'(m_x2[k]) * coef(5*k+2) - longint'(m_y1[k]) * coef(5*k+3)
          - longint'(m_y2[k]) * coef(5*k+4);
      sh = (acc + 64'sd8192) >>> 14;
`ifdef IIR_SAT_EN
      if (sh > 32767) begin so = 32767; m_ovf = 1'b1; end
      else if (sh < -32768) begin so = -32768; m_ovf = 1'b1; end
      else so = int'(sh);
`else
      t  = sh[15:0];
      so = int'($signed(t));
`endif
      m_x2[k] = m_x1[k];
      m_x1[k] = s;
      m_y2[k] = m_y1[k];
      m_y1[k] = so;
      s = so;
    end
    y = s[15:0];
  endtask

  // One full transaction: wait for ready, offer a sample, collect the output
  task automatic send(input logic [15:0] d, output logic [15:0] y);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
    in_data  = '0;
    n = 0;
    while (!out_valid && n < 60) begin step(); n++; end
    chk("resp_valid", 32'(out_valid), 32'd1);
    y = out_data;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] y;
    logic [15:0] e;
    int n;

    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h4000;
    out_ready = 1'b0;
    mdl_reset();
    repeat (3) step();
    chk("rst_in_ready",  32'(in_ready),   32'd1);
    chk("rst_out_valid", 32'(out_valid),  32'd0);
    chk("rst_out_data",  32'(out_data),   32'h0000);
    chk("rst_addr",      32'(coeff_addr), 32'd0);
    chk("rst_busy",      32'(busy),       32'd0);
`ifdef IIR_SAT_EN
    chk("rst_ovf",       32'(ovf),        32'd0);
`endif
    in_valid = 1'b0;
    in_data  = '0;
    rst_n    = 1'b1;
    step();
    step();

    // Zero input keeps zero history
    for (int i = 0; i < 3; i++) begin
      send(16'h0000, y);
      mdl_step(16'h0000, e);
      chk($sformatf("zero[%0d]", i), 32'(y), 32'h0000);
    end

    // Impulse with cycle-accurate timing of the MAC address sequence
    chk("idle_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = 16'h4000;
    step();
    in_valid = 1'b0;
    in_data  = '0;
    for (int k = 0; k < 25; k++) begin
      chk($sformatf("addr[%0d]", k), 32'(coeff_addr), 32'(k));
      chk($sformatf("run_ready[%0d]", k), 32'(in_ready), 32'd0);
      chk($sformatf("run_valid[%0d]", k), 32'(out_valid), 32'd0);
      step();
    end
    chk("done_valid", 32'(out_valid),  32'd1);
    chk("imp_first",  32'(out_data),   32'h0009);
    chk("done_busy",  32'(busy),       32'd1);
    chk("done_addr",  32'(coeff_addr), 32'd0);
    mdl_step(16'h4000, e);

    // Backpressure: output held, inputs ignored
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2) == 1;
      in_data  = 16'h7FFF;
      step();
      chk($sformatf("bp_valid[%0d]", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp_data[%0d]", i),  32'(out_data),  32'h0009);
      chk($sformatf("bp_ready[%0d]", i), 32'(in_ready),  32'd0);
    end
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("hs_valid", 32'(out_valid), 32'd0);
    chk("hs_ready", 32'(in_ready),  32'd1);
    chk("hs_busy",  32'(busy),      32'd0);

    // Impulse tail against the reference
    for (int i = 1; i <= 200; i++) begin
      send(16'h0000, y);
      mdl_step(16'h0000, e);
      chk($sformatf("imp[%0d]", i), 32'(y), 32'(e));
    end

    // Reset in the middle of a run
    in_valid = 1'b1;
    in_data  = 16'h4000;
    step();
    in_valid = 1'b0;
    in_data  = '0;
    n = 0;
    while (coeff_addr != 5'd12 && n < 40) begin step(); n++; end
    chk("reach_addr12", 32'(coeff_addr), 32'd12);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(in_ready),   32'd1);
    chk("mid_rst_busy",  32'(busy),       32'd0);
    chk("mid_rst_addr",  32'(coeff_addr), 32'd0);
    chk("mid_rst_valid", 32'(out_valid),  32'd0);
    step();
    rst_n = 1'b1;
    mdl_reset();
    step();
    step();
    chk("no_partial", 32'(out_valid), 32'd0);
    send(16'h4000, y);
    mdl_step(16'h4000, e);
    chk("imp2_first", 32'(y), 32'h0009);
    for (int i = 1; i <= 30; i++) begin
      send(16'h0000, y);
      mdl_step(16'h0000, e);
      chk($sformatf("imp2[%0d]", i), 32'(y), 32'(e));
    end

    // Full-scale step
    for (int i = 0; i < 100; i++) begin
      send(16'h7FFF, y);
      mdl_step(16'h7FFF, e);
      chk($sformatf("step[%0d]", i), 32'(y), 32'(e));
`ifdef IIR_SAT_EN
      chk($sformatf("ovf[%0d]", i), 32'(ovf), 32'(m_ovf));
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
